uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of byte sources sharing one UART transmitter (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum idle cycles an owner may hold a lock.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port req_data  input  8*NUM_REQ  byte from requester i on bits [8i+7:8i].
REQ-006 SHALL have port req_valid  input  NUM_REQ  requester i has a byte.
REQ-007 SHALL have port req_last  input  NUM_REQ  byte from requester i ends its message.
REQ-008 SHALL have port req_ready  output  NUM_REQ  byte from requester i accepted this cycle.
REQ-009 SHALL have port out_data  output  8  byte to uart data_in.
REQ-010 SHALL have port out_valid  output  1  to uart data_in_valid.
REQ-011 SHALL have port out_ready  input  1  from uart data_in_ready.
REQ-012 SHALL have port grant_id  output  $clog2(NUM_REQ)  current or selected requester index.
REQ-013 SHALL have port locked  output  1  high while in LOCKED.
REQ-014 SHALL have port timeout_pulse  output  1  one-cycle strobe on forced lock release.

Function
REQ-015 SHALL implement FSM states IDLE and LOCKED; registers: state, rr_ptr, owner, idle_cnt.
REQ-016 In IDLE, winner SHALL be the first requester with req_valid high, searching from rr_ptr upward with wrap-around modulo NUM_REQ.
REQ-017 In LOCKED, winner SHALL be owner regardless of other req_valid.
REQ-018 Datapath SHALL be combinational: out_data = req_data[winner], out_valid = req_valid[winner], req_ready[winner] = out_ready, all other req_ready = 0; zero-cycle latency.
REQ-019 In IDLE with no req_valid, out_valid SHALL be 0 and grant_id SHALL equal rr_ptr.
REQ-020 A transfer occurs when out_valid and out_ready are both high.
REQ-021 An IDLE transfer with req_last=1 SHALL stay in IDLE and set rr_ptr = winner+1 mod NUM_REQ.
REQ-022 An IDLE transfer with req_last=0 SHALL move to LOCKED, set owner = winner, and clear idle_cnt.
REQ-023 A LOCKED transfer with req_last=1 SHALL move to IDLE and set rr_ptr = owner+1 mod NUM_REQ.
REQ-024 In LOCKED, idle_cnt SHALL increment each cycle req_valid[owner]=0, saturating, and SHALL clear on any cycle req_valid[owner]=1.
REQ-025 In LOCKED with req_valid[owner]=0 and idle_cnt = TIMEOUT_CYCLES-1, the block SHALL move to IDLE, set rr_ptr = owner+1, and assert timeout_pulse for exactly the next cycle.
REQ-026 Requesters SHALL hold req_data/req_last stable while req_valid is high and unaccepted; the arbiter SHALL NOT re-arbitrate in IDLE while the current winner's req_valid stays high.
REQ-027 The previous IDLE winner SHALL be registered so grant persists across stalled cycles (out_ready=0).
REQ-028 When NUM_REQ is not a power of two, rr_ptr and owner wrap from NUM_REQ-1 to 0.

Reset
REQ-029 While reset_n=0: state=IDLE, rr_ptr=0, owner=0, idle_cnt=0, timeout_pulse=0, out_valid=0, all req_ready=0, locked=0.
REQ-030 Reset asserted mid-message SHALL abandon the lock immediately; no byte is accepted in the reset cycle.

Structure
REQ-031 NUM_REQ default, TIMEOUT_CYCLES default and IDLE/LOCKED state encodings SHALL live in the shared package uart_pkg.
REQ-032 Round-robin priority selection SHALL be a sub-module rr_select (inputs req mask, rr_ptr; output index, any).

Verification
REQ-033 Single source: req 2 sends 0x41 last=1, out_ready=1 -> out_data=0x41 same cycle, req_ready[2]=1, rr_ptr becomes 3.
REQ-034 Contention: req 0,1,3 valid single bytes 0x10,0x11,0x13, rr_ptr=0 -> output order 0x10,0x11,0x13, rr_ptr ends at 0.
REQ-035 Lock: req 1 sends "HI" (0x48 last=0, 0x49 last=1) while req 0 valid -> 0x48,0x49 contiguous, locked high between them, then req 0 granted.
REQ-036 Stall: out_ready=0 for 20 cycles with req 3 valid, then req 0 raises valid -> grant_id stays 3, req 3 byte sent first.
REQ-037 Timeout (TIMEOUT_CYCLES=16): req 2 sends 0x55 last=0 then drops valid -> timeout_pulse one cycle after 16 idle cycles, state IDLE, rr_ptr=3.
REQ-038 System: arbiter feeding uart with two sources at 125 MHz/115200 baud into off-chip uart -> received bytes match sent order; reset_n pulse mid-message -> out_valid=0 immediately, recovery without lock.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared defaults and state encoding for the UART transmit arbiter.
package uart_pkg;

    localparam int NUM_REQ_DEF        = 4;
    localparam int TIMEOUT_CYCLES_DEF = 1024;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_select.sv
// Round-robin priority pick: first set bit of req at or above rr_ptr, wrapping modulo N.
module rr_select #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] rr_ptr,
    output logic [ID_W-1:0] index,
    output logic            any
);

    int j;

    // Scan from the farthest offset down so the nearest hit is assigned last.
    always_comb begin
        index = rr_ptr;
        any   = 1'b0;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(rr_ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (req[j]) begin
                index = ID_W'(j);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte sources; multi-byte messages lock the grant.
//
//   state     | meaning
//   ST_IDLE   | round-robin arbitration; single-byte messages complete here
//   ST_LOCKED | owner holds the transmitter until its last byte or an idle timeout
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = NUM_REQ_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       locked,
    output logic                       timeout_pulse
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

    arb_state_t      state, state_nxt;
    logic [ID_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [ID_W-1:0] owner, owner_nxt;
    logic [ID_W-1:0] hold_id, hold_id_nxt;
    logic            hold_vld, hold_vld_nxt;
    logic [CNT_W-1:0] idle_cnt, idle_cnt_nxt;
    logic            timeout_nxt;

    logic [ID_W-1:0] rr_idx;
    logic            rr_any;
    logic [ID_W-1:0] winner;
    logic            has_winner;
    logic [7:0]      sel_data;
    logic            sel_valid;
    logic            sel_last;
    logic            xfer;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] idx);
        return (idx == ID_LAST) ? '0 : idx + 1'b1;
    endfunction

    rr_select #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_rr_select (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .index  (rr_idx),
        .any    (rr_any)
    );

    // A stalled IDLE winner keeps the grant while it still presents its byte.
    always_comb begin
        if (state == ST_LOCKED) begin
            winner     = owner;
            has_winner = 1'b1;
        end else if (hold_vld && req_valid[hold_id]) begin
            winner     = hold_id;
            has_winner = 1'b1;
        end else begin
            winner     = rr_idx;
            has_winner = rr_any;
        end
    end

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                sel_data  = req_data[8*i +: 8];
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = reset_n & has_winner & out_ready & (winner == ID_W'(i));
        end
    end

    assign out_data  = sel_data;
    assign out_valid = reset_n & has_winner & sel_valid;
    assign xfer      = out_valid & out_ready;
    assign grant_id  = winner;
    assign locked    = (state == ST_LOCKED);

    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        owner_nxt    = owner;
        idle_cnt_nxt = idle_cnt;
        hold_vld_nxt = 1'b0;
        hold_id_nxt  = hold_id;
        timeout_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                idle_cnt_nxt = '0;
                if (xfer) begin
                    if (sel_last) begin
                        rr_ptr_nxt = wrap_inc(winner);
                    end else begin
                        state_nxt = ST_LOCKED;
                        owner_nxt = winner;
                    end
                end else if (out_valid) begin
                    hold_vld_nxt = 1'b1;
                    hold_id_nxt  = winner;
                end
            end
            ST_LOCKED: begin
                if (xfer && sel_last) begin
                    state_nxt    = ST_IDLE;
                    rr_ptr_nxt   = wrap_inc(owner);
                    idle_cnt_nxt = '0;
                end else if (sel_valid) begin
                    idle_cnt_nxt = '0;
                end else if (idle_cnt == CNT_LAST) begin
                    state_nxt    = ST_IDLE;
                    rr_ptr_nxt   = wrap_inc(owner);
                    idle_cnt_nxt = '0;
                    timeout_nxt  = 1'b1;
                end else begin
                    idle_cnt_nxt = idle_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            owner         <= '0;
            idle_cnt      <= '0;
            hold_vld      <= 1'b0;
            hold_id       <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            rr_ptr        <= rr_ptr_nxt;
            owner         <= owner_nxt;
            idle_cnt      <= idle_cnt_nxt;
            hold_vld      <= hold_vld_nxt;
            hold_id       <= hold_id_nxt;
            timeout_pulse <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scenarios plus randomized multi-source traffic against a behavioural arbiter model.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic [7:0]      out_data;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      grant_id;
    logic            locked;
    logic            timeout_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    bit            m_locked;
    int            m_rr;
    int            m_owner;
    int            m_cnt;
    bit            m_hold_vld;
    int            m_hold;
    bit            m_tp;
    logic [NR-1:0] m_acc;

    int s_left[NR];
    int s_gap[NR];

    logic [7:0] t2_bytes[3] = '{8'h10, 8'h11, 8'h13};
    int         t2_ids[3]   = '{0, 1, 3};

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_data      (req_data),
        .req_valid     (req_valid),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .grant_id      (grant_id),
        .locked        (locked),
        .timeout_pulse (timeout_pulse)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NR-1:0] v, input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (v[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    task automatic drive(input int i, input bit v, input logic [7:0] d, input bit l);
        req_valid[i]       = v;
        req_data[8*i +: 8] = d;
        req_last[i]        = l;
    endtask

    task automatic model_reset();
        m_locked   = 1'b0;
        m_rr       = 0;
        m_owner    = 0;
        m_cnt      = 0;
        m_hold_vld = 1'b0;
        m_hold     = 0;
        m_tp       = 1'b0;
        m_acc      = '0;
    endtask

    // One clock cycle: compare outputs against the model, advance the model, move to next cycle.
    task automatic step();
        int            w;
        int            eg;
        bit            ev;
        bit            lst;
        logic [NR-1:0] emask;
        #1;
        m_acc = '0;
        if (!reset_n) begin
            check_val("rst_out_valid", 32'(out_valid), 32'd0);
            check_val("rst_req_ready", 32'(req_ready), 32'd0);
            check_val("rst_locked", 32'(locked), 32'd0);
            check_val("rst_timeout", 32'(timeout_pulse), 32'd0);
            model_reset();
        end else begin
            if (m_locked) w = m_owner;
            else if (m_hold_vld && req_valid[m_hold]) w = m_hold;
            else w = pick(req_valid, m_rr);
            ev = 1'b0;
            lst = 1'b0;
            if (w >= 0) begin
                ev  = req_valid[w];
                lst = req_last[w];
            end
            eg = (w >= 0) ? w : m_rr;
            emask = '0;
            if (ev && out_ready) emask[w] = 1'b1;

            check_val("out_valid", 32'(out_valid), 32'(ev));
            if (ev) check_val("out_data", 32'(out_data), 32'(req_data[8*w +: 8]));
            check_val("grant_id", 32'(grant_id), 32'(eg));
            check_val("req_ready", 32'(req_ready & req_valid), 32'(emask));
            check_val("locked", 32'(locked), 32'(m_locked));
            check_val("timeout_pulse", 32'(timeout_pulse), 32'(m_tp));

            m_acc      = emask;
            m_tp       = 1'b0;
            m_hold_vld = 1'b0;
            if (!m_locked) begin
                if (ev && out_ready) begin
                    if (lst) begin
                        m_rr = (w + 1) % NR;
                    end else begin
                        m_locked = 1'b1;
                        m_owner  = w;
                        m_cnt    = 0;
                    end
                end else if (ev) begin
                    m_hold_vld = 1'b1;
                    m_hold     = w;
                end
            end else begin
                if (ev && out_ready && lst) begin
                    m_locked = 1'b0;
                    m_rr     = (m_owner + 1) % NR;
                end else if (ev) begin
                    m_cnt = 0;
                end else if (m_cnt == TO - 1) begin
                    m_locked = 1'b0;
                    m_rr     = (m_owner + 1) % NR;
                    m_tp     = 1'b1;
                    m_cnt    = 0;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
        end
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset_n   = 1'b0;
        req_data  = '0;
        req_valid = '0;
        req_last  = '0;
        out_ready = 1'b0;
        model_reset();
        #1;
        check_val("reset_grant", 32'(grant_id), 32'd0);
        step();
        step();
        reset_n = 1'b1;

        // Single source
        out_ready = 1'b1;
        drive(2, 1'b1, 8'h41, 1'b1);
        #1;
        check_val("single_data", 32'(out_data), 32'h41);
        check_val("single_ready", 32'(req_ready), 32'b0100);
        step();
        drive(2, 1'b0, 8'h00, 1'b0);
        #1;
        check_val("single_rr", 32'(grant_id), 32'd3);

        // Contention from rr_ptr = 0
        drive(3, 1'b1, 8'h33, 1'b1);
        step();
        drive(3, 1'b0, 8'h00, 1'b0);
        drive(0, 1'b1, 8'h10, 1'b1);
        drive(1, 1'b1, 8'h11, 1'b1);
        drive(3, 1'b1, 8'h13, 1'b1);
        for (int k = 0; k < 3; k++) begin
            #1;
            check_val("contend_order", 32'(out_data), 32'(t2_bytes[k]));
            step();
            drive(t2_ids[k], 1'b0, 8'h00, 1'b0);
        end
        #1;
        check_val("contend_rr_end", 32'(grant_id), 32'd0);

        // Locked two-byte message
        drive(0, 1'b1, 8'h20, 1'b1);
        step();
        drive(0, 1'b1, 8'h30, 1'b1);
        drive(1, 1'b1, 8'h48, 1'b0);
        #1;
        check_val("lock_first", 32'(out_data), 32'h48);
        step();
        drive(1, 1'b1, 8'h49, 1'b1);
        #1;
        check_val("lock_held", 32'(locked), 32'd1);
        check_val("lock_second", 32'(out_data), 32'h49);
        step();
        drive(1, 1'b0, 8'h00, 1'b0);
        #1;
        check_val("lock_released", 32'(locked), 32'd0);
        check_val("lock_next_src", 32'(out_data), 32'h30);
        step();
        drive(0, 1'b0, 8'h00, 1'b0);

        // Stall keeps the grant
        out_ready = 1'b0;
        drive(3, 1'b1, 8'h77, 1'b1);
        repeat (20) step();
        #1;
        check_val("stall_grant", 32'(grant_id), 32'd3);
        drive(0, 1'b1, 8'h01, 1'b1);
        repeat (3) step();
        #1;
        check_val("stall_grant_contend", 32'(grant_id), 32'd3);
        out_ready = 1'b1;
        #1;
        check_val("stall_first", 32'(out_data), 32'h77);
        step();
        drive(3, 1'b0, 8'h00, 1'b0);
        #1;
        check_val("stall_second", 32'(out_data), 32'h01);
        step();
        drive(0, 1'b0, 8'h00, 1'b0);

        // Idle timeout on an abandoned lock
        drive(2, 1'b1, 8'h55, 1'b0);
        step();
        drive(2, 1'b0, 8'h00, 1'b0);
        repeat (TO - 1) step();
        #1;
        check_val("timeout_early_locked", 32'(locked), 32'd1);
        check_val("timeout_early_pulse", 32'(timeout_pulse), 32'd0);
        step();
        #1;
        check_val("timeout_pulse", 32'(timeout_pulse), 32'd1);
        check_val("timeout_unlocked", 32'(locked), 32'd0);
        check_val("timeout_rr", 32'(grant_id), 32'd3);
        step();
        #1;
        check_val("timeout_pulse_once", 32'(timeout_pulse), 32'd0);

        // Reset mid-message
        drive(1, 1'b1, 8'h60, 1'b0);
        step();
        drive(1, 1'b1, 8'h61, 1'b0);
        #1;
        reset_n = 1'b0;
        #1;
        check_val("midrst_valid", 32'(out_valid), 32'd0);
        check_val("midrst_ready", 32'(req_ready), 32'd0);
        check_val("midrst_locked", 32'(locked), 32'd0);
        step();
        reset_n = 1'b1;
        drive(1, 1'b1, 8'h62, 1'b1);
        #1;
        check_val("midrst_recover_valid", 32'(out_valid), 32'd1);
        check_val("midrst_recover_lock", 32'(locked), 32'd0);
        step();
        drive(1, 1'b0, 8'h00, 1'b0);

        // Randomized traffic
        for (int i = 0; i < NR; i++) begin
            s_left[i] = 0;
            s_gap[i]  = 0;
        end
        m_acc = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NR; i++) begin
                if (m_acc[i]) begin
                    s_left[i]    = s_left[i] - 1;
                    req_valid[i] = 1'b0;
                    s_gap[i] = ($urandom_range(0, 15) == 0) ? 20 : int'($urandom_range(0, 3));
                end
                if (!req_valid[i]) begin
                    if (s_gap[i] > 0) begin
                        s_gap[i] = s_gap[i] - 1;
                    end else begin
                        if (s_left[i] <= 0 && $urandom_range(0, 3) == 0) s_left[i] = int'($urandom_range(1, 4));
                        if (s_left[i] > 0) drive(i, 1'b1, 8'($urandom_range(0, 255)), s_left[i] == 1);
                    end
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            reset_n   = (cyc != 1500);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
